// File: rtl/UART_pkg.sv
// rtl/UART_pkg.sv - shared UART receive-side types, limits and config helper
//
// Purpose: state encoding for the receive sequencer, legal data-width limits,
// and the helper that turns a CSR data width into the index of the last data bit.
// Ports: none (package).
package UART_pkg;

    localparam int UART_MIN_DATA_BITS = 5;
    localparam int UART_MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } uart_rx_state_t;

    // Index of the final data bit; widths outside 5..8 fall back to 8 bits.
    function automatic logic [3:0] last_data_bit(input logic [3:0] data_bits);
        if (data_bits >= 4'(UART_MIN_DATA_BITS) && data_bits <= 4'(UART_MAX_DATA_BITS))
            return data_bits - 4'd1;
        return 4'(UART_MAX_DATA_BITS - 1);
    endfunction

endpackage

// File: rtl/UART_rx_sync.sv
// rtl/UART_rx_sync.sv - multi-flop synchronizer for the asynchronous rx line
//
// Purpose: brings the raw serial line into the clk domain. The chain presets to 1
// (line idle) so reset never looks like a start bit.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   rx    in  raw asynchronous serial line
//   rx_s  out synchronized line, SYNC_STAGES cycles behind rx
module UART_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst)
            chain <= '1;
        else
            chain <= {chain[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_control.sv
// rtl/uart_rx_control.sv - UART receive sequencer driving the RX datapath strobes
//
// Purpose: detects start bits on the synchronized line, frames start/data/parity/
// stop bits using the wait-bit timer strobes, and drives the datapath shift and
// frame-done strobes plus framing/overrun error pulses.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rx                              raw serial line (idle high)
//   half_bit, wait_bit_done         mid-bit / end-of-bit strobes from the timer
//   data_bits, parity_en, two_stop  frame format, latched at each start bit
//   rx_data_valid, rx_data_ready    datapath output handshake (overrun detect)
//   wait_bit_en, wait_bit_rst_n     timer enable / active-low timer reset
//   shift_bits, done                one-cycle datapath strobes
//   framing_error, overrun_error    one-cycle error pulses, coincident with done
//   busy                            high whenever a frame is in progress
module uart_rx_control
    import UART_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       half_bit,
    input  logic       wait_bit_done,
    input  logic [3:0] data_bits,
    input  logic       parity_en,
    input  logic       two_stop,
    input  logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       wait_bit_en,
    output logic       wait_bit_rst_n,
    output logic       shift_bits,
    output logic       done,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       busy
);

    logic           rx_s;
    uart_rx_state_t state;
    logic [3:0]     bit_cnt;
    logic [3:0]     last_bit;
    logic           stop_cnt;
    logic           parity_l;
    logic           two_stop_l;
    logic           frame_bad;

    UART_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    // Pulse outputs are registered on the edge that makes the transition, so
    // done and its error flags are all visible during the single DONE cycle.
    // wait_bit_done is tested before half_bit so a coincident pair skips the
    // mid-bit check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            last_bit      <= 4'(UART_MAX_DATA_BITS - 1);
            stop_cnt      <= 1'b0;
            parity_l      <= 1'b0;
            two_stop_l    <= 1'b0;
            frame_bad     <= 1'b0;
            shift_bits    <= 1'b0;
            done          <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            shift_bits    <= 1'b0;
            done          <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state      <= ST_START;
                        last_bit   <= last_data_bit(data_bits);
                        parity_l   <= parity_en;
                        two_stop_l <= two_stop;
                        frame_bad  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (wait_bit_done) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end else if (half_bit && rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (wait_bit_done) begin
                        shift_bits <= 1'b1;
                        bit_cnt    <= bit_cnt + 4'd1;
                        stop_cnt   <= 1'b0;
                        if (bit_cnt == last_bit)
                            state <= parity_l ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (wait_bit_done) begin
                        shift_bits <= 1'b1;
                        stop_cnt   <= 1'b0;
                        state      <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (wait_bit_done) begin
                        if (two_stop_l && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            state         <= ST_DONE;
                            done          <= 1'b1;
                            framing_error <= frame_bad;
                            overrun_error <= rx_data_valid & ~rx_data_ready;
                        end
                    end else if (half_bit && !rx_s) begin
                        frame_bad <= 1'b1;
                    end
                end
                ST_DONE: begin
                    frame_bad <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Timer runs only while a frame is being framed; DONE and IDLE hold it reset.
    assign wait_bit_en    = (state == ST_START) || (state == ST_DATA) ||
                            (state == ST_PARITY) || (state == ST_STOP);
    assign wait_bit_rst_n = wait_bit_en;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_control.sv
// tb/tb_uart_rx_control.sv - self-checking bench for uart_rx_control
module tb_uart_rx_control;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       half_bit = 1'b0;
    logic       wait_bit_done = 1'b0;
    logic [3:0] data_bits = 4'd8;
    logic       parity_en = 1'b0;
    logic       two_stop = 1'b0;
    logic       rx_data_valid = 1'b0;
    logic       rx_data_ready = 1'b1;
    logic       wait_bit_en, wait_bit_rst_n, shift_bits, done;
    logic       framing_error, overrun_error, busy;

    uart_rx_control #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx),
        .half_bit       (half_bit),
        .wait_bit_done  (wait_bit_done),
        .data_bits      (data_bits),
        .parity_en      (parity_en),
        .two_stop       (two_stop),
        .rx_data_valid  (rx_data_valid),
        .rx_data_ready  (rx_data_ready),
        .wait_bit_en    (wait_bit_en),
        .wait_bit_rst_n (wait_bit_rst_n),
        .shift_bits     (shift_bits),
        .done           (done),
        .framing_error  (framing_error),
        .overrun_error  (overrun_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Wait-bit timer model: free-running bit period of BIT cycles.
    int tcnt = 0;
    always @(posedge clk) begin
        if (!wait_bit_rst_n) begin
            tcnt          <= 0;
            half_bit      <= 1'b0;
            wait_bit_done <= 1'b0;
        end else if (wait_bit_en) begin
            half_bit      <= (tcnt == BIT / 2 - 1);
            wait_bit_done <= (tcnt == BIT - 1);
            tcnt          <= (tcnt == BIT - 1) ? 0 : tcnt + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         nshift;
        logic       ferr;
        logic       oerr;
        int         done_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] raw;
        int          nshift;
        logic        ferr;
        logic        oerr;
        int          done_cyc;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];

    // Monitor: datapath-style sampling at half_bit, capture at shift_bits.
    logic        sample = 1'b1;
    logic        wbd_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic [15:0] raw = '0;
    int          nsh = 0;
    int          shift_total = 0, done_total = 0;
    int          shift_bad = 0, done_bad = 0, stray_err = 0, busy_bad = 0;

    always @(negedge clk) begin
        obs_t o;
        if (rst) begin
            nsh = 0;
            raw = '0;
        end else begin
            if (shift_bits) begin
                if (!wbd_prev) shift_bad++;
                shift_total++;
                if (nsh < 16) raw[nsh] = sample;
                nsh++;
            end
            if (half_bit) sample = rx;
            if (done) begin
                if (!wbd_prev) done_bad++;
                done_total++;
                o.raw      = raw;
                o.nshift   = nsh;
                o.ferr     = framing_error;
                o.oerr     = overrun_error;
                o.done_cyc = cyc;
                obs_q.push_back(o);
                nsh = 0;
                raw = '0;
            end
            if ((framing_error || overrun_error) && !done) stray_err++;
            if (done_prev && busy) busy_bad++;
        end
        wbd_prev  = wait_bit_done;
        done_prev = done;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic ns2, input logic stop_lvl, input logic scramble,
                              input logic oerr);
        exp_t e;
        logic [7:0] m;
        int nstop;
        m        = 8'((1 << nb) - 1);
        nstop    = ns2 ? 2 : 1;
        data_bits = 4'(nb);
        parity_en = pen;
        two_stop  = ns2;
        e.data     = d & m;
        e.nbits    = nb;
        e.nshift   = nb + int'(pen);
        e.ferr     = ~stop_lvl;
        e.oerr     = oerr;
        e.done_cyc = cyc + BIT * (1 + nb + int'(pen) + nstop) + 4;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        if (scramble) begin
            data_bits = 4'd8;
            parity_en = 1'b0;
            two_stop  = 1'b0;
        end
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (pen) begin
            rx = ^(d & m);
            repeat (BIT) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            rx = stop_lvl;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        obs_t o;
        logic [15:0] m;
        for (int i = 0; i < 100 && obs_q.size() == 0; i++) @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "_done_seen"}, 32'(obs_q.size() > 0), 32'd1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            m = 16'((1 << e.nbits) - 1);
            chk({tag, "_data"}, 32'(o.raw & m), 32'(e.data));
            chk({tag, "_nshift"}, 32'(o.nshift), 32'(e.nshift));
            chk({tag, "_ferr"}, 32'(o.ferr), 32'(e.ferr));
            chk({tag, "_oerr"}, 32'(o.oerr), 32'(e.oerr));
            chk({tag, "_done_cyc"}, 32'(o.done_cyc), 32'(e.done_cyc));
        end
        repeat (3 * BIT) @(negedge clk);
    endtask

    initial begin
        int lat;
        int n;
        int snap_shift, snap_done;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wait_bit_en", 32'(wait_bit_en), 32'd0);
        chk("rst_wait_bit_rst_n", 32'(wait_bit_rst_n), 32'd0);
        chk("rst_shift", 32'(shift_bits), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_errs", 32'({framing_error, overrun_error}), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("f8n1");

        // 7E2 0x3C, CSR changed mid-frame must not matter
        send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_frame("f7e2");

        // Glitch: 4 low cycles then high before half_bit
        snap_shift = shift_total;
        snap_done  = done_total;
        lat = -1;
        rx  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (busy && lat < 0) lat = i;
        end
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_start_latency", 32'(lat), 32'd3);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_no_shift", 32'(shift_total), 32'(snap_shift));
        chk("glitch_no_done", 32'(done_total), 32'(snap_done));

        // 5N1 with low stop bit, then a good 5N1 frame
        send_frame(8'h12, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("f5n1_bad_stop");
        send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("f5n1_good");

        // Overrun: consumer not ready, first frame left pending
        rx_data_ready = 1'b0;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("ovr_first");
        rx_data_valid = 1'b1;
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_frame("ovr_second");
        rx_data_valid = 1'b0;
        rx_data_ready = 1'b1;

        // Reset after the 3rd shift of an 8N1 frame
        data_bits = 4'd8;
        parity_en = 1'b0;
        two_stop  = 1'b0;
        snap_done = done_total;
        n = 0;
        for (int k = 0; k < BIT * 9 && n < 3; k++) begin
            rx = (k < BIT) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (shift_bits) n++;
        end
        chk("rst_mid_reached_shift3", 32'(n), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_wait_bit_rst_n", 32'(wait_bit_rst_n), 32'd0);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (300) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_total), 32'(snap_done));
        chk("rst_mid_obs_empty", 32'(obs_q.size()), 32'd0);

        chk("shift_after_wbd", 32'(shift_bad), 32'd0);
        chk("done_after_wbd", 32'(done_bad), 32'd0);
        chk("err_only_with_done", 32'(stray_err), 32'd0);
        chk("busy_low_after_done", 32'(busy_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
